// File: rtl/instr_memory_server.sv
// Single-port instruction memory server: host write port plus one-at-a-time read port with snoop broadcast.
// Optional macro IMEM_OUTPUT_REG_EN adds a RAM output register stage (RD_PIPE), giving 3-cycle read latency.
module instr_memory_server #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int STAT_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] rd_addr,
  output logic                         rd_ready,
  output logic [MEMORY_WIDTH-1:0]      rd_data,
  output logic                         broadcast_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0] broadcast_addr,
  input  logic                         wr_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [MEMORY_WIDTH-1:0]      wr_data,
  output logic                         wr_ready,
  output logic                         busy,
  output logic [STAT_WIDTH-1:0]        read_count,
  output logic [STAT_WIDTH-1:0]        write_count
);

`ifdef IMEM_OUTPUT_REG_EN
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_PIPE, RD_RESP, WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_RESP, WR} state_t;
`endif

  state_t state, state_next;

  logic [MEMORY_WIDTH-1:0]      mem [0:(2**MEMORY_ADDR_WIDTH)-1];
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Writes win over reads in IDLE; a write still held next IDLE is a fresh write.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (wr_valid)      state_next = WR;
        else if (rd_valid) state_next = RD_ISSUE;
      end
`ifdef IMEM_OUTPUT_REG_EN
      RD_ISSUE: state_next = RD_PIPE;
      RD_PIPE:  state_next = RD_RESP;
`else
      RD_ISSUE: state_next = RD_RESP;
`endif
      RD_RESP:  state_next = IDLE;
      WR:       state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_ready        = 1'b0;
    broadcast_valid = 1'b0;
    wr_ready        = 1'b0;
    busy            = (state != IDLE);
    if (state == RD_RESP) begin
      rd_ready        = 1'b1;
      broadcast_valid = 1'b1;
    end
    if (state == WR) wr_ready = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      addr_q <= '0;
    else if (state == IDLE && !wr_valid && rd_valid) addr_q <= rd_addr;
  end

  // State is forced to IDLE asynchronously, so a reset before the WR edge blocks the write.
  always_ff @(posedge clk) begin
    if (state == WR) mem[wr_addr] <= wr_data;
  end

`ifdef IMEM_OUTPUT_REG_EN
  logic [MEMORY_WIDTH-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (state == RD_ISSUE) ram_q <= mem[addr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data        <= '0;
      broadcast_addr <= '0;
    end else if (state == RD_PIPE) begin
      rd_data        <= ram_q;
      broadcast_addr <= addr_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data        <= '0;
      broadcast_addr <= '0;
    end else if (state == RD_ISSUE) begin
      rd_data        <= mem[addr_q];
      broadcast_addr <= addr_q;
    end
  end
`endif

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (state == RD_RESP && read_count != '1)
        read_count <= read_count + STAT_WIDTH'(1);
      if (state == WR && write_count != '1)
        write_count <= write_count + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instr_memory_server.sv
// Self-checking bench for instr_memory_server: scoreboard of expected read words plus a
// second instance with 4-bit counters for saturation.
module tb_instr_memory_server;
  localparam int AW = 11;
  localparam int DW = 16;
`ifdef IMEM_OUTPUT_REG_EN
  localparam int RD_LAT = 3;
`else
  localparam int RD_LAT = 2;
`endif
  localparam int RD_PERIOD = RD_LAT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic          rd_ready, broadcast_valid, wr_ready, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] broadcast_addr;
  logic [31:0]   read_count, write_count;

  logic          s_rd_ready, s_broadcast_valid, s_wr_ready, s_busy;
  logic [DW-1:0] s_rd_data;
  logic [AW-1:0] s_broadcast_addr;
  logic [3:0]    s_read_count, s_write_count;

  instr_memory_server dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .broadcast_valid(broadcast_valid), .broadcast_addr(broadcast_addr),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .read_count(read_count), .write_count(write_count)
  );

  instr_memory_server #(.STAT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(s_rd_ready), .rd_data(s_rd_data),
    .broadcast_valid(s_broadcast_valid), .broadcast_addr(s_broadcast_addr),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(s_wr_ready),
    .busy(s_busy), .read_count(s_read_count), .write_count(s_write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [0:(2**AW)-1];
  int            model_reads = 0;
  int            model_writes = 0;
  int            checks = 0;
  int            passed = 0;

  // Drives one read and waits (bounded) for rd_ready; lat stays -1 on timeout.
  task automatic issue_read(input logic [AW-1:0] a, output int lat, output logic [DW-1:0] d,
                            output logic [AW-1:0] ba, output logic bv);
    exp_q.push_back('{addr: a, data: model_mem[a]});
    model_reads++;
    rd_addr = a;
    rd_valid = 1'b1;
    lat = -1; d = '0; ba = '0; bv = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (rd_ready) begin
        lat = k; d = rd_data; ba = broadcast_addr; bv = broadcast_valid;
        break;
      end
    end
    rd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] v, output int lat);
    model_mem[a] = v;
    model_writes++;
    wr_addr = a; wr_data = v; wr_valid = 1'b1;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (wr_ready) begin
        lat = k;
        break;
      end
    end
    wr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_ready, rd_data, broadcast_valid, broadcast_addr, wr_ready, busy, read_count, write_count} !== '0) begin
      $display("[TB] FAIL reset_outputs: got rd_ready=%b rd_data=%h bv=%b ba=%h wr_ready=%b busy=%b rc=%0d wc=%0d, want all 0",
               rd_ready, rd_data, broadcast_valid, broadcast_addr, wr_ready, busy, read_count, write_count);
    end else passed++;
    checks++;
    if ({s_rd_ready, s_rd_data, s_broadcast_valid, s_broadcast_addr, s_wr_ready, s_busy, s_read_count, s_write_count} !== '0) begin
      $display("[TB] FAIL reset_outputs_sat: got rc=%0d wc=%0d busy=%b, want all 0", s_read_count, s_write_count, s_busy);
    end else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_readback();
    int lat;
    logic [DW-1:0] d;
    logic [AW-1:0] ba;
    logic bv;
    exp_t e;
    issue_write(11'd5, 16'hBEEF, lat);
    checks++;
    if (lat !== 1) $display("[TB] FAIL wr_latency: got %0d, want 1", lat); else passed++;
    checks++;
    if (wr_ready !== 1'b0) $display("[TB] FAIL wr_ready_width: got %b, want 0", wr_ready); else passed++;
    checks++;
    if (write_count !== 32'(model_writes)) $display("[TB] FAIL write_count: got %0d, want %0d", write_count, model_writes); else passed++;

    issue_read(11'd5, lat, d, ba, bv);
    e = exp_q.pop_front();
    checks++;
    if (lat !== RD_LAT) $display("[TB] FAIL rd_latency: got %0d, want %0d", lat, RD_LAT); else passed++;
    checks++;
    if (d !== e.data) $display("[TB] FAIL rd_data: got %h, want %h", d, e.data); else passed++;
    checks++;
    if (ba !== e.addr || bv !== 1'b1) $display("[TB] FAIL broadcast: got addr=%0d valid=%b, want addr=%0d valid=1", ba, bv, e.addr); else passed++;
    checks++;
    if (read_count !== 32'(model_reads)) $display("[TB] FAIL read_count: got %0d, want %0d", read_count, model_reads); else passed++;
    checks++;
    if (busy !== 1'b0 || rd_ready !== 1'b0) $display("[TB] FAIL idle_after_read: got busy=%b rd_ready=%b, want 0 0", busy, rd_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4];
    logic [DW-1:0] vals  [4];
    int lat;
    logic [DW-1:0] d;
    logic [AW-1:0] ba;
    logic bv;
    exp_t e;
    addrs[0] = 11'd0;    vals[0] = 16'h0A0A;
    addrs[1] = 11'd2047; vals[1] = 16'hFFFF;
    addrs[2] = 11'd3;    vals[2] = 16'h1234;
    addrs[3] = 11'd2046; vals[3] = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
      issue_write(addrs[i], vals[i], lat);
      checks++;
      if (lat !== 1) $display("[TB] FAIL b2b_wr_latency[%0d]: got %0d, want 1", i, lat); else passed++;
    end
    for (int i = 3; i >= 0; i--) begin
      issue_read(addrs[i], lat, d, ba, bv);
      e = exp_q.pop_front();
      checks++;
      if (lat !== RD_LAT || d !== e.data || ba !== e.addr)
        $display("[TB] FAIL b2b_read[%0d]: got lat=%0d data=%h addr=%0d, want lat=%0d data=%h addr=%0d",
                 i, lat, d, ba, RD_LAT, e.data, e.addr);
      else passed++;
    end
    checks++;
    if (write_count !== 32'(model_writes) || read_count !== 32'(model_reads))
      $display("[TB] FAIL b2b_counts: got wc=%0d rc=%0d, want wc=%0d rc=%0d", write_count, read_count, model_writes, model_reads);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int lat, wr_k, rd_k;
    logic [DW-1:0] d;
    exp_t e;
    issue_write(11'd7, 16'h1111, lat);
    model_mem[7] = 16'h2222;
    model_writes++;
    model_reads++;
    exp_q.push_back('{addr: 11'd7, data: 16'h2222});
    rd_addr = 11'd7; rd_valid = 1'b1;
    wr_addr = 11'd7; wr_data = 16'h2222; wr_valid = 1'b1;
    wr_k = -1; rd_k = -1; d = '0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (wr_ready && wr_k < 0) begin
        wr_k = k;
        wr_valid = 1'b0;
      end
      if (rd_ready && rd_k < 0) begin
        rd_k = k;
        d = rd_data;
        rd_valid = 1'b0;
        break;
      end
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (wr_k !== 1) $display("[TB] FAIL sim_wr_first: got wr_ready at cycle %0d, want 1", wr_k); else passed++;
    checks++;
    if (rd_k - wr_k !== RD_PERIOD) $display("[TB] FAIL sim_rd_gap: got %0d, want %0d", rd_k - wr_k, RD_PERIOD); else passed++;
    checks++;
    if (d !== e.data) $display("[TB] FAIL sim_rd_data: got %h, want %h", d, e.data); else passed++;
  endtask

  task automatic test_held_valid();
    int lat, n_exp, pulses, wide, bad_gap, last_i;
    logic prev;
    exp_t e;
    issue_write(11'd3, 16'hC3C3, lat);
    n_exp = (10 + RD_PERIOD - 1) / RD_PERIOD;
    for (int j = 0; j < n_exp; j++) exp_q.push_back('{addr: 11'd3, data: 16'hC3C3});
    model_reads += n_exp;
    pulses = 0; wide = 0; bad_gap = 0; last_i = -1; prev = 1'b0;
    rd_addr = 11'd3; rd_valid = 1'b1;
    for (int i = 1; i <= 10 + RD_PERIOD + 3; i++) begin
      @(posedge clk); #1;
      if (rd_ready) begin
        pulses++;
        if (prev) wide++;
        if (last_i >= 0 && i - last_i != RD_PERIOD) bad_gap++;
        last_i = i;
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL held_extra_pulse: got pulse %0d, want none", pulses);
        else begin
          e = exp_q.pop_front();
          if (rd_data !== e.data || broadcast_addr !== e.addr)
            $display("[TB] FAIL held_data: got %h@%0d, want %h@%0d", rd_data, broadcast_addr, e.data, e.addr);
          else passed++;
        end
      end
      prev = rd_ready;
      if (i == 10) rd_valid = 1'b0;
    end
    checks++;
    if (pulses !== n_exp) $display("[TB] FAIL held_pulses: got %0d, want %0d", pulses, n_exp); else passed++;
    checks++;
    if (wide !== 0 || bad_gap !== 0) $display("[TB] FAIL held_shape: got wide=%0d badgap=%0d, want 0 0", wide, bad_gap); else passed++;
    checks++;
    if (read_count !== 32'(model_reads)) $display("[TB] FAIL held_read_count: got %0d, want %0d", read_count, model_reads); else passed++;
    checks++;
    if (exp_q.size() !== 0) $display("[TB] FAIL held_missing: got %0d outstanding, want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat, seen;
    logic [DW-1:0] d;
    logic [AW-1:0] ba;
    logic bv;
    exp_t e;
    rd_addr = 11'd5; rd_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL abort_busy_before: got %b, want 1", busy); else passed++;
    rst = 1'b1;
    #1;
    rd_valid = 1'b0;
    model_reads = 0;
    model_writes = 0;
    checks++;
    if ({rd_ready, rd_data, broadcast_valid, broadcast_addr, wr_ready, busy, read_count, write_count} !== '0)
      $display("[TB] FAIL abort_outputs: got rd_ready=%b rd_data=%h busy=%b rc=%0d wc=%0d, want all 0",
               rd_ready, rd_data, busy, read_count, write_count);
    else passed++;
    seen = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (rd_ready) seen++;
    end
    checks++;
    if (seen !== 0) $display("[TB] FAIL abort_no_ready: got %0d pulses, want 0", seen); else passed++;
    issue_read(11'd5, lat, d, ba, bv);
    e = exp_q.pop_front();
    checks++;
    if (lat !== RD_LAT || d !== e.data || ba !== e.addr || bv !== 1'b1)
      $display("[TB] FAIL abort_reread: got lat=%0d data=%h addr=%0d bv=%b, want lat=%0d data=%h addr=%0d bv=1",
               lat, d, ba, bv, RD_LAT, e.data, e.addr);
    else passed++;
    checks++;
    if (read_count !== 32'(model_reads)) $display("[TB] FAIL abort_read_count: got %0d, want %0d", read_count, model_reads); else passed++;
  endtask

  task automatic test_saturation();
    logic [AW-1:0] alist [4];
    int lat;
    logic [DW-1:0] d;
    logic [AW-1:0] ba;
    logic bv;
    logic [3:0] exp_sat;
    exp_t e;
    alist[0] = 11'd5; alist[1] = 11'd7; alist[2] = 11'd2047; alist[3] = 11'd0;
    for (int i = 0; i < 20; i++) begin
      issue_read(alist[i % 4], lat, d, ba, bv);
      e = exp_q.pop_front();
      checks++;
      if (lat !== RD_LAT || d !== e.data)
        $display("[TB] FAIL sat_read[%0d]: got lat=%0d data=%h, want lat=%0d data=%h", i, lat, d, RD_LAT, e.data);
      else passed++;
    end
    exp_sat = (model_reads >= 15) ? 4'hF : 4'(model_reads);
    checks++;
    if (s_read_count !== exp_sat) $display("[TB] FAIL sat_read_count: got %0d, want %0d", s_read_count, exp_sat); else passed++;
    checks++;
    if (read_count !== 32'(model_reads)) $display("[TB] FAIL wide_read_count: got %0d, want %0d", read_count, model_reads); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_back_to_back();
    test_simultaneous();
    test_held_valid();
    test_reset_abort();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
